// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: issues sequential word fetches, buffers PC-tagged
// responses in a small FIFO and presents them to decode with a valid/nStall handshake.
module instr_prefetch #(
    parameter int DEPTH = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      Clock,
    input  logic                      nReset,
    output logic                      IMemReq,
    output logic [ADDR_W-1:0]         IMemAddr,
    input  logic [DATA_W-1:0]         IMemData,
    input  logic                      Redirect,
    input  logic [ADDR_W-1:0]         RedirectPC,
    output logic                      InstrValid,
    output logic [DATA_W-1:0]         InstrOut,
    output logic [ADDR_W-1:0]         InstrPC,
    input  logic                      nStall,
    output logic [$clog2(DEPTH):0]    Level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetchPc;
    logic              inflight;
    logic [ADDR_W-1:0] inflightPc;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [ADDR_W-1:0] pcMem   [DEPTH];

    logic push;
    logic pop;
    logic unusedRedirectLsb;

    assign unusedRedirectLsb = ^RedirectPC[1:0];

    // Space is judged on registered occupancy plus the outstanding response only;
    // a same-cycle pop never frees a slot for this cycle's request.
    always_comb begin
        IMemReq    = nReset && !Redirect && ((int'(level) + int'(inflight)) < DEPTH);
        IMemAddr   = fetchPc;
        InstrValid = (level != '0);
        InstrOut   = dataMem[rdPtr];
        InstrPC    = pcMem[rdPtr];
        Level      = level;
        push       = inflight;
        pop        = InstrValid && nStall;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            fetchPc    <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            level      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dataMem[i] <= '0;
                pcMem[i]   <= '0;
            end
        end else if (Redirect) begin
            // Clearing inflight drops the response arriving this cycle.
            fetchPc  <= {RedirectPC[ADDR_W-1:2], 2'b00};
            inflight <= 1'b0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            level    <= '0;
        end else begin
            inflight <= IMemReq;
            if (IMemReq) begin
                inflightPc <= fetchPc;
                fetchPc    <= fetchPc + ADDR_W'(4);
            end
            if (push) begin
                dataMem[wrPtr] <= IMemData;
                pcMem[wrPtr]   <= inflightPc;
                wrPtr          <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: a per-cycle vector table plus a hand-written
// stall/release sequence; memory returns 0xA000_0000 | address one cycle after a request.
module tb_instr_prefetch;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic [31:0] IMemData;
    logic        Redirect = 1'b0;
    logic [15:0] RedirectPC = '0;
    logic        InstrValid;
    logic [31:0] InstrOut;
    logic [15:0] InstrPC;
    logic        nStall = 1'b1;
    logic [2:0]  Level;

    always #5 Clock = ~Clock;

    instr_prefetch #(
        .DEPTH(4),
        .ADDR_W(16),
        .DATA_W(32),
        .RESET_PC(16'h0000)
    ) dut (
        .Clock(Clock),
        .nReset(nReset),
        .IMemReq(IMemReq),
        .IMemAddr(IMemAddr),
        .IMemData(IMemData),
        .Redirect(Redirect),
        .RedirectPC(RedirectPC),
        .InstrValid(InstrValid),
        .InstrOut(InstrOut),
        .InstrPC(InstrPC),
        .nStall(nStall),
        .Level(Level)
    );

    logic [15:0] memAddrQ = '0;
    always @(posedge Clock) memAddrQ <= IMemAddr;
    assign IMemData = {16'hA000, memAddrQ};

    typedef struct {
        logic        rstN;
        logic        redir;
        logic [15:0] rpc;
        logic        ns;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [2:0]  lvl;
        logic        chk;
        logic [15:0] pc;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(logic rstN, logic redir, logic [15:0] rpc, logic ns,
                                logic req, logic [15:0] addr, logic valid,
                                logic [2:0] lvl, logic [15:0] pc);
        vec_t v;
        v.rstN = rstN; v.redir = redir; v.rpc = rpc; v.ns = ns;
        v.req = req; v.addr = addr; v.valid = valid; v.lvl = lvl;
        v.chk  = !rstN || valid;
        v.pc   = pc;
        v.data = valid ? {16'hA000, pc} : 32'h0;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [15:0] relPc [5] = '{16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0018};

    initial begin
        // reset
        vecs.push_back(mk(0,0,16'h0000,1, 0,16'h0000,0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,1, 0,16'h0000,0,0,16'h0000));
        // streaming from reset, no bubbles
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0000,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0004,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0008,1,1,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h000C,1,1,16'h0004));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0010,1,1,16'h0008));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0014,1,1,16'h000C));
        // async reset mid-stream, then stall from reset until full
        vecs.push_back(mk(0,0,16'h0000,1, 0,16'h0000,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,0, 1,16'h0000,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,0, 1,16'h0004,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,0, 1,16'h0008,1,1,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,0, 1,16'h000C,1,2,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,0, 0,16'h0010,1,3,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,0, 0,16'h0010,1,4,16'h0000));
        // single pop at full: no request that cycle
        vecs.push_back(mk(1,0,16'h0000,1, 0,16'h0010,1,4,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,0, 1,16'h0010,1,3,16'h0004));
        // push and pop together keep level
        vecs.push_back(mk(1,0,16'h0000,1, 0,16'h0014,1,3,16'h0004));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0014,1,3,16'h0008));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0018,1,2,16'h000C));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h001C,1,2,16'h0010));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0020,1,2,16'h0014));
        vecs.push_back(mk(1,0,16'h0000,0, 1,16'h0024,1,2,16'h0018));
        // redirect at level 3 with a response in flight
        vecs.push_back(mk(1,1,16'h0102,1, 0,16'h0028,1,3,16'h0018));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0100,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0104,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0108,1,1,16'h0100));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h010C,1,1,16'h0104));
        // back-to-back redirects, last wins, address wrap
        vecs.push_back(mk(1,1,16'h0200,1, 0,16'h0110,1,1,16'h0108));
        vecs.push_back(mk(1,1,16'hFFF8,1, 0,16'h0200,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'hFFF8,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'hFFFC,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0000,1,1,16'hFFF8));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0004,1,1,16'hFFFC));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0008,1,1,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h000C,1,1,16'h0004));
        vecs.push_back(mk(1,0,16'h0000,0, 1,16'h0010,1,1,16'h0008));
        // reset at level 2 with a request in flight; restart at RESET_PC
        vecs.push_back(mk(0,0,16'h0000,1, 0,16'h0000,0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,1, 0,16'h0000,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0000,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0004,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h0008,1,1,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,1, 1,16'h000C,1,1,16'h0004));

        foreach (vecs[i]) begin
            @(posedge Clock);
            #1;
            nReset     = vecs[i].rstN;
            Redirect   = vecs[i].redir;
            RedirectPC = vecs[i].rpc;
            nStall     = vecs[i].ns;
            #3;
            check($sformatf("v%0d IMemReq", i), 32'(IMemReq), 32'(vecs[i].req));
            check($sformatf("v%0d IMemAddr", i), 32'(IMemAddr), 32'(vecs[i].addr));
            check($sformatf("v%0d InstrValid", i), 32'(InstrValid), 32'(vecs[i].valid));
            check($sformatf("v%0d Level", i), 32'(Level), 32'(vecs[i].lvl));
            if (vecs[i].chk) begin
                check($sformatf("v%0d InstrPC", i), 32'(InstrPC), 32'(vecs[i].pc));
                check($sformatf("v%0d InstrOut", i), InstrOut, vecs[i].data);
            end
        end

        // stall long enough to fill, head must hold steady
        for (int k = 0; k < 6; k++) begin
            @(posedge Clock);
            #1;
            nStall = 1'b0;
            #3;
            if (k >= 3) check($sformatf("stall%0d InstrPC", k), 32'(InstrPC), 32'h0008);
        end
        check("full Level", 32'(Level), 32'd4);
        check("full IMemReq", 32'(IMemReq), 32'd0);
        check("full IMemAddr", 32'(IMemAddr), 32'h0018);
        check("full InstrOut", InstrOut, 32'hA000_0008);

        // release: one pop per cycle in order, requests resume one cycle later
        for (int k = 0; k < 5; k++) begin
            @(posedge Clock);
            #1;
            nStall = 1'b1;
            #3;
            check($sformatf("rel%0d InstrValid", k), 32'(InstrValid), 32'd1);
            check($sformatf("rel%0d InstrPC", k), 32'(InstrPC), 32'(relPc[k]));
            check($sformatf("rel%0d InstrOut", k), InstrOut, {16'hA000, relPc[k]});
            if (k == 0) check("rel0 IMemReq", 32'(IMemReq), 32'd0);
            if (k == 1) begin
                check("rel1 IMemReq", 32'(IMemReq), 32'd1);
                check("rel1 IMemAddr", 32'(IMemAddr), 32'h0018);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
